tw_arbiter: RTL and testbench

- Shares one threewire master between N_REQ requesters.
- Latches one request at a time, sequences the master's start/in-progress handshake, and returns read data with a one-cycle acknowledge.
- Grants are round-robin; a watchdog recovers from a master that never starts or never finishes.
- Sits between the register-access clients and the threewire master instance.

---
 rtl/tw_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tw_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tw_arbiter.sv
// Round-robin arbiter sharing one threewire master among N_REQ requesters,
// with a per-transaction watchdog and one-cycle ack/err completion.
module tw_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GRANT_BITS     = 2,
    parameter int ADDR_BITS      = 9,
    parameter int DATA_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                           in_clk,
    input  logic                           in_rst,
    input  logic [N_REQ-1:0]               in_req,
    input  logic [N_REQ-1:0]               in_req_mode_wr,
    input  logic [N_REQ*ADDR_BITS-1:0]     in_req_addr,
    input  logic [N_REQ*DATA_BITS-1:0]     in_req_wr_data,
    output logic [N_REQ-1:0]               out_ack,
    output logic                           out_err,
    output logic [DATA_BITS-1:0]           out_rd_data,
    output logic [GRANT_BITS-1:0]          out_grant,
    output logic                           out_busy,
    output logic                           out_tw_start,
    output logic                           out_tw_mode_wr,
    output logic [ADDR_BITS-1:0]           out_tw_addr,
    output logic [DATA_BITS-1:0]           out_tw_wr_data,
    input  logic [DATA_BITS-1:0]           in_tw_rd_data,
    input  logic                           in_tw_active
);

    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [GRANT_BITS:0] N_REQ_W = (GRANT_BITS + 1)'(N_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [GRANT_BITS-1:0] r_ptr;
    logic [GRANT_BITS-1:0] r_grant;
    logic [WD_BITS-1:0]    r_wd;
    logic [N_REQ-1:0]      r_ack;
    logic                  r_err;
    logic [DATA_BITS-1:0]  r_rd_data;
    logic                  r_busy;
    logic                  r_tw_start;
    logic                  r_tw_mode_wr;
    logic [ADDR_BITS-1:0]  r_tw_addr;
    logic [DATA_BITS-1:0]  r_tw_wr_data;

    logic [N_REQ-1:0]      w_rot;
    logic [GRANT_BITS-1:0] w_off;
    logic [GRANT_BITS:0]   w_sum;
    logic [GRANT_BITS-1:0] w_pick;
    logic [GRANT_BITS:0]   w_inc;
    logic [GRANT_BITS-1:0] w_next_ptr;
    logic [N_REQ-1:0]      w_onehot;
    logic                  w_wd_expired;

    // Requests rotated so bit 0 is the pointer; lowest set bit wins.
    assign w_rot = N_REQ'({in_req, in_req} >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = GRANT_BITS'(k);
            end
        end
    end

    assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_pick = (w_sum >= N_REQ_W) ? GRANT_BITS'(w_sum - N_REQ_W)
                                       : w_sum[GRANT_BITS-1:0];

    assign w_inc      = {1'b0, r_grant} + (GRANT_BITS + 1)'(1);
    assign w_next_ptr = (w_inc == N_REQ_W) ? '0 : w_inc[GRANT_BITS-1:0];

    assign w_onehot     = N_REQ'(1) << r_grant;
    assign w_wd_expired = (r_wd == WD_LAST);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_wd         <= '0;
            r_ack        <= '0;
            r_err        <= 1'b0;
            r_rd_data    <= '0;
            r_busy       <= 1'b0;
            r_tw_start   <= 1'b0;
            r_tw_mode_wr <= 1'b0;
            r_tw_addr    <= '0;
            r_tw_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A master still busy from before blocks any new grant.
                    if ((|in_req) && !in_tw_active) begin
                        r_grant      <= w_pick;
                        r_tw_mode_wr <= in_req_mode_wr[w_pick];
                        r_tw_addr    <= in_req_addr[w_pick*ADDR_BITS +: ADDR_BITS];
                        r_tw_wr_data <= in_req_wr_data[w_pick*DATA_BITS +: DATA_BITS];
                        r_tw_start   <= 1'b1;
                        r_wd         <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    if (in_tw_active) begin
                        r_tw_start <= 1'b0;
                        r_wd       <= r_wd + 1'b1;
                        r_state    <= S_BUSY;
                    end else if (w_wd_expired) begin
                        r_tw_start <= 1'b0;
                        r_ack      <= w_onehot;
                        r_err      <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!in_tw_active) begin
                        if (!r_tw_mode_wr) begin
                            r_rd_data <= in_tw_rd_data;
                        end
                        r_ack   <= w_onehot;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_wd_expired) begin
                        r_ack   <= w_onehot;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_ptr   <= w_next_ptr;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_ack        = r_ack;
    assign out_err        = r_err;
    assign out_rd_data    = r_rd_data;
    assign out_grant      = r_grant;
    assign out_busy       = r_busy;
    assign out_tw_start   = r_tw_start;
    assign out_tw_mode_wr = r_tw_mode_wr;
    assign out_tw_addr    = r_tw_addr;
    assign out_tw_wr_data = r_tw_wr_data;

endmodule

// File: tb/tb_tw_arbiter.sv
// Directed bench for tw_arbiter: behavioural threewire slave plus an
// in-order scoreboard of expected acks, checked with immediate assertions.
module tb_tw_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  mode;
    logic [35:0] addr;
    logic [63:0] wdat;
    logic [3:0]  out_ack;
    logic        out_err;
    logic [15:0] out_rd_data;
    logic [1:0]  out_grant;
    logic        out_busy;
    logic        out_tw_start;
    logic        out_tw_mode_wr;
    logic [8:0]  out_tw_addr;
    logic [15:0] out_tw_wr_data;
    logic [15:0] tw_rd;
    logic        tw_active;

    logic        slave_en;
    logic [8:0]  cap_addr;
    logic [15:0] cap_data;
    logic        cap_mode;
    logic [15:0] last_rd;

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  ack;
        logic        err;
        logic [15:0] rd;
    } exp_t;

    exp_t q[$];

    tw_arbiter #(
        .N_REQ(4),
        .GRANT_BITS(2),
        .ADDR_BITS(9),
        .DATA_BITS(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .in_clk(clk),
        .in_rst(rst_n),
        .in_req(req),
        .in_req_mode_wr(mode),
        .in_req_addr(addr),
        .in_req_wr_data(wdat),
        .out_ack(out_ack),
        .out_err(out_err),
        .out_rd_data(out_rd_data),
        .out_grant(out_grant),
        .out_busy(out_busy),
        .out_tw_start(out_tw_start),
        .out_tw_mode_wr(out_tw_mode_wr),
        .out_tw_addr(out_tw_addr),
        .out_tw_wr_data(out_tw_wr_data),
        .in_tw_rd_data(tw_rd),
        .in_tw_active(tw_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave read data derived from the address: 0x003 -> 0x003D.
    function automatic logic [15:0] model_rd(logic [8:0] a);
        return {3'b000, a, 4'hD};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_fields(int i, logic wr, logic [8:0] a, logic [15:0] d);
        mode[i]          = wr;
        addr[i*9 +: 9]   = a;
        wdat[i*16 +: 16] = d;
    endtask

    task automatic push(logic [3:0] a, logic e, logic [15:0] rd);
        exp_t x;
        x.ack = a;
        x.err = e;
        x.rd  = rd;
        q.push_back(x);
    endtask

    task automatic push_rd(int i, logic [8:0] a);
        last_rd = model_rd(a);
        push(4'(1 << i), 1'b0, last_rd);
    endtask

    // Scoreboard; requesters drop their request on their own ack.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (|out_ack) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", 32'(out_ack), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack", 32'(out_ack), 32'(e.ack));
                    chk("err", 32'(out_err), 32'(e.err));
                    chk("rd_data", 32'(out_rd_data), 32'(e.rd));
                end
                req = req & ~out_ack;
            end
        end
    endtask

    task automatic slave();
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!slave_en) begin
                tw_active = 1'b0;
            end else if (!tw_active && out_tw_start && cnt == 0) begin
                tw_active = 1'b1;
                cnt       = 3;
                cap_addr  = out_tw_addr;
                cap_data  = out_tw_wr_data;
                cap_mode  = out_tw_mode_wr;
            end else if (tw_active) begin
                cnt--;
                if (cnt <= 0) begin
                    cnt       = 0;
                    tw_active = 1'b0;
                    if (!cap_mode) tw_rd = model_rd(cap_addr);
                end
            end
        end
    endtask

    task automatic wait_busy(string tag);
        int n;
        n = 0;
        while (!out_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_busy) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_done(string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_busy) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int starts;
        logic got;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req       = '0;
        mode      = '0;
        addr      = '0;
        wdat      = '0;
        tw_rd     = '0;
        tw_active = 1'b0;
        slave_en  = 1'b1;
        cap_addr  = '0;
        cap_data  = '0;
        cap_mode  = 1'b0;
        last_rd   = '0;
        fork
            monitor();
            slave();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_ack", 32'(out_ack), 32'd0);
        chk("rst_start", 32'(out_tw_start), 32'd0);
        chk("rst_grant", 32'(out_grant), 32'd0);
        chk("rst_rd_data", 32'(out_rd_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read from requester 1.
        set_fields(1, 1'b0, 9'h003, 16'h0000);
        push_rd(1, 9'h003);
        req[1] = 1'b1;
        wait_busy("rd_busy_timeout");
        chk("rd_tw_addr", 32'(out_tw_addr), 32'h003);
        chk("rd_tw_mode", 32'(out_tw_mode_wr), 32'd0);
        chk("rd_grant", 32'(out_grant), 32'd1);
        wait_done("rd_done_timeout");

        // Single write from requester 2; read data must hold.
        set_fields(2, 1'b1, 9'h04E, 16'h0049);
        push(4'b0100, 1'b0, last_rd);
        req[2] = 1'b1;
        wait_done("wr_done_timeout");
        chk("wr_slave_addr", 32'(cap_addr), 32'h04E);
        chk("wr_slave_data", 32'(cap_data), 32'h0049);
        chk("wr_slave_mode", 32'(cap_mode), 32'd1);

        // Reset mid-BUSY with pointer at 3.
        set_fields(3, 1'b0, 9'h020, 16'h0000);
        req[3] = 1'b1;
        n = 0;
        while (!(tw_active && !out_tw_start && out_busy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_reached", 32'(tw_active && out_busy), 32'd1);
        rst_n   = 1'b0;
        req     = '0;
        last_rd = '0;
        #1;
        chk("mid_rst_start", 32'(out_tw_start), 32'd0);
        chk("mid_rst_ack", 32'(out_ack), 32'd0);
        chk("mid_rst_busy", 32'(out_busy), 32'd0);
        chk("mid_rst_active", 32'(tw_active), 32'd1);
        set_fields(2, 1'b0, 9'h030, 16'h0000);
        set_fields(3, 1'b0, 9'h031, 16'h0000);
        push_rd(2, 9'h030);
        push_rd(3, 9'h031);
        req = 4'b1100;
        @(negedge clk);
        rst_n = 1'b1;
        wait_busy("post_rst_busy_timeout");
        chk("post_rst_grant", 32'(out_grant), 32'd2);
        wait_done("post_rst_done_timeout");

        // Fairness: pointer 0, requesters 0 and 3 together.
        set_fields(0, 1'b0, 9'h040, 16'h0000);
        set_fields(3, 1'b0, 9'h043, 16'h0000);
        push_rd(0, 9'h040);
        push_rd(3, 9'h043);
        req = 4'b1001;
        wait_done("fair_a_timeout");
        set_fields(0, 1'b0, 9'h041, 16'h0000);
        push_rd(0, 9'h041);
        req[0] = 1'b1;
        wait_done("fair_b_timeout");
        for (int i = 0; i < 4; i++) begin
            set_fields(i, 1'b0, 9'(9'h050 + i), 16'h0000);
        end
        push_rd(1, 9'h051);
        push_rd(2, 9'h052);
        push_rd(3, 9'h053);
        push_rd(0, 9'h050);
        req = 4'b1111;
        wait_done("fair_c_timeout");

        // Watchdog with a master that never starts.
        slave_en = 1'b0;
        set_fields(0, 1'b0, 9'h060, 16'h0000);
        push(4'b0001, 1'b1, last_rd);
        req[0] = 1'b1;
        starts = 0;
        got    = 1'b0;
        n      = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (out_tw_start) starts++;
            if (out_ack[0]) got = 1'b1;
        end
        chk("wd_ack_seen", 32'(got), 32'd1);
        chk("wd_start_cycles", 32'(starts), 32'd16);
        wait_done("wd_done_timeout");
        slave_en = 1'b1;

        // Requester 1 drops its request one cycle into the transaction.
        set_fields(1, 1'b0, 9'h070, 16'h0000);
        push_rd(1, 9'h070);
        req[1] = 1'b1;
        n = 0;
        while (!out_tw_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drop_start_seen", 32'(out_tw_start), 32'd1);
        @(negedge clk);
        req[1] = 1'b0;
        wait_done("drop_done_timeout");
        repeat (5) @(negedge clk);
        chk("drop_no_regrant", 32'(out_busy), 32'd0);
        chk("drop_grant_kept", 32'(out_grant), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
